// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Opcode and sequencer-state encodings shared by the ALU demo
//                sequencer, the ALU and the display driver.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W_PKG = 3;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_SUB  = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } seq_state_t;

    // Only the four implemented operations may be committed to the ALU.
    function automatic logic is_valid_op(alu_op_t code);
        return (code == OP_ADD) || (code == OP_AND) ||
               (code == OP_OR)  || (code == OP_SUB);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Two-flop synchroniser for a debounced push button followed
//                by a rising-edge detector. A held button yields one pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronise the asynchronous button and keep a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign pulse = r_s2 & ~r_s3;

endmodule : btn_edge
`default_nettype wire

// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_sequencer
//  Description : One-button entry controller: latches operand A, operand B and
//                an opcode from the slide switches, pulses exec on a commit
//                and op_err when an unimplemented opcode is offered.
//                Optional macro ALU_SEQ_LIVE_PREVIEW_EN makes a/b follow the
//                switches while their entry phase is active.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int OP_W = OP_W_PKG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    sw,
    input  logic            btn_next,
    input  logic            btn_clear,
    output logic [W-1:0]    a,
    output logic [W-1:0]    b,
    output logic [OP_W-1:0] op,
    output logic [1:0]      phase,
    output logic            exec,
    output logic            op_err
);

    logic            w_next_pulse;
    logic            w_clear_pulse;
    alu_op_t         w_op_cand;

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    w_a_nxt;
    logic [W-1:0]    r_b;
    logic [W-1:0]    w_b_nxt;
    logic [OP_W-1:0] r_op;
    logic [OP_W-1:0] w_op_nxt;
    logic            r_exec;
    logic            w_exec_nxt;
    logic            r_op_err;
    logic            w_op_err_nxt;

    btn_edge u_next_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_next),
        .pulse (w_next_pulse)
    );

    btn_edge u_clear_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .pulse (w_clear_pulse)
    );

    assign w_op_cand = alu_op_t'(sw[OP_W-1:0]);

    // State register plus the operand, opcode and strobe registers it controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_exec   <= 1'b0;
            r_op_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_exec   <= w_exec_nxt;
            r_op_err <= w_op_err_nxt;
        end
    end

    // Next-state and next-register values; clear wins over a coincident step.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_exec_nxt   = 1'b0;
        w_op_err_nxt = 1'b0;

        if (w_clear_pulse) begin
            w_state_nxt = S_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
        end else begin
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
            // Display follows the switches during operand entry.
            if (r_state == S_A) w_a_nxt = sw;
            if (r_state == S_B) w_b_nxt = sw;
`endif
            if (w_next_pulse) begin
                case (r_state)
                    S_A: begin
                        w_a_nxt     = sw;
                        w_state_nxt = S_B;
                    end
                    S_B: begin
                        w_b_nxt     = sw;
                        w_state_nxt = S_OP;
                    end
                    S_OP: begin
                        if (is_valid_op(w_op_cand)) begin
                            w_op_nxt    = sw[OP_W-1:0];
                            w_state_nxt = S_SHOW;
                            w_exec_nxt  = 1'b1;
                        end else begin
                            w_op_err_nxt = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = S_A;
                    end
                endcase
            end
        end
    end

    assign a      = r_a;
    assign b      = r_b;
    assign op     = r_op;
    assign phase  = r_state;
    assign exec   = r_exec;
    assign op_err = r_op_err;

endmodule : alu_input_sequencer
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_input_sequencer
//  Description : Directed self-checking bench for alu_input_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_input_sequencer;

    localparam int W    = 8;
    localparam int OP_W = 3;

    logic            clk;
    logic            reset;
    logic [W-1:0]    sw;
    logic            btn_next;
    logic            btn_clear;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [OP_W-1:0] op;
    logic [1:0]      phase;
    logic            exec;
    logic            op_err;

    int n_vec;
    int n_err;
    int exec_seen;
    int exec_before;

    alu_input_sequencer #(.W(W), .OP_W(OP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn_next  (btn_next),
        .btn_clear (btn_clear),
        .a         (a),
        .b         (b),
        .op        (op),
        .phase     (phase),
        .exec      (exec),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count exec pulses sampled mid-cycle.
    always @(negedge clk) begin
        if (exec) exec_seen = exec_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press; the FSM acts on the third edge after the rise.
    task automatic press();
        btn_next = 1'b1;
        tick(1);
        btn_next = 1'b0;
        tick(3);
    endtask

    // Same as press(), checking exec/op_err on the edges around the commit.
    task automatic press_chk(input string tag, input logic e_exec, input logic e_err);
        btn_next = 1'b1;
        tick(1);
        btn_next = 1'b0;
        tick(1);
        chk({tag, " exec@2"}, exec, 1'b0);
        chk({tag, " err@2"}, op_err, 1'b0);
        tick(1);
        chk({tag, " exec@3"}, exec, e_exec);
        chk({tag, " err@3"}, op_err, e_err);
        tick(1);
        chk({tag, " exec@4"}, exec, 1'b0);
        chk({tag, " err@4"}, op_err, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exec_seen = 0;
        reset = 1'b1;
        sw = '0;
        btn_next = 1'b0;
        btn_clear = 1'b0;

        // 1. reset
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst a", a, 8'h00);
        chk("rst b", b, 8'h00);
        chk("rst op", op, 3'b000);
        chk("rst phase", phase, 2'd0);
        chk("rst exec", exec, 1'b0);
        chk("rst op_err", op_err, 1'b0);

        // 2. full entry sequence
        sw = 8'h2A; press();
        chk("seq phase after A", phase, 2'd1);
        sw = 8'h15; press();
        chk("seq phase after B", phase, 2'd2);
        sw = 8'h01; press_chk("seq commit", 1'b1, 1'b0);
        chk("seq a", a, 8'h2A);
        chk("seq b", b, 8'h15);
        chk("seq op", op, 3'b001);
        chk("seq phase", phase, 2'd3);

        // 3. invalid opcode rejected, then valid SUB
        press();
        chk("show->A phase", phase, 2'd0);
        chk("show->A a held", a, 8'h2A);
        sw = 8'hC3; press();
        sw = 8'h5A; press();
        sw = 8'h06; press_chk("bad op", 1'b0, 1'b1);
        chk("bad op phase", phase, 2'd2);
        chk("bad op op", op, 3'b001);
        sw = 8'h04; press_chk("sub op", 1'b1, 1'b0);
        chk("sub op", op, 3'b100);
        chk("sub phase", phase, 2'd3);
        chk("sub a", a, 8'hC3);
        chk("sub b", b, 8'h5A);

        // 4. held button -> exactly one step
        press();
        chk("hold start phase", phase, 2'd0);
        sw = 8'h77;
        btn_next = 1'b1;
        tick(50);
        chk("hold mid phase", phase, 2'd1);
        btn_next = 1'b0;
        tick(4);
        chk("hold end phase", phase, 2'd1);
        chk("hold a", a, 8'h77);

        // 5. next and clear together in S_B
        exec_before = exec_seen;
        sw = 8'h99;
        btn_next = 1'b1;
        btn_clear = 1'b1;
        tick(1);
        btn_next = 1'b0;
        btn_clear = 1'b0;
        tick(4);
        chk("clr phase", phase, 2'd0);
        chk("clr a", a, 8'h00);
        chk("clr b", b, 8'h00);
        chk("clr op", op, 3'b000);
        chk("clr no exec", exec_seen - exec_before, 0);

        // 5b. reset in S_OP after a committed op
        sw = 8'h10; press();
        sw = 8'h20; press();
        sw = 8'h03; press();
        chk("pre op", op, 3'b011);
        press();
        sw = 8'h11; press();
        sw = 8'h22; press();
        chk("pre-rst phase", phase, 2'd2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("rst2 phase", phase, 2'd0);
        chk("rst2 a", a, 8'h00);
        chk("rst2 b", b, 8'h00);
        chk("rst2 op", op, 3'b000);

        // 6. preview behaviour in S_A
        for (int i = 0; i < 4; i++) begin
            sw = 8'(i * 8'h55);
            tick(1);
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
            chk("preview a", a, 8'(i * 8'h55));
`else
            chk("no preview a", a, 8'h00);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu_input_sequencer
`default_nettype wire
